// File: rtl/tail_light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tail_light_pkg
//  Description : Shared types, lamp constants and helpers for the tail-light
//                sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tail_light_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } tl_state_t;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_ALL = 3'b111;

    // Walking pattern, bit0 is the innermost lamp.
    function automatic logic [2:0] pat(input logic [1:0] phase);
        logic [2:0] lamps;
        case (phase)
            2'd0:    lamps = 3'b001;
            2'd1:    lamps = 3'b011;
            2'd2:    lamps = 3'b111;
            default: lamps = 3'b000;
        endcase
        return lamps;
    endfunction

    // Request arbitration applied at every decision point.
    function automatic tl_state_t decide(input logic left, input logic right,
                                         input logic hazard);
        tl_state_t nxt;
        if (hazard || (left && right)) nxt = HAZARD;
        else if (left)                 nxt = LEFT;
        else if (right)                nxt = RIGHT;
        else                           nxt = IDLE;
        return nxt;
    endfunction

endpackage : tail_light_pkg
`default_nettype wire

// File: rtl/light_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : light_step_timer
//  Description : Step prescaler and 2-bit pattern phase counter; flags the
//                tick that ends phase 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_step_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       wrap
);

    localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          tick;

    always_comb begin
        tick    = (pcnt_q == LAST);
        wrap    = run && tick && (phase_q == 2'd3);
        pcnt_d  = pcnt_q;
        phase_d = phase_q;
        if (clr) begin
            pcnt_d  = '0;
            phase_d = 2'd0;
        end else if (run) begin
            if (tick) begin
                pcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                pcnt_d  = pcnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q  <= '0;
            phase_q <= 2'd0;
        end else begin
            pcnt_q  <= pcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule : light_step_timer
`default_nettype wire

// File: rtl/tail_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tail_light_ctrl
//  Description : Tail-light sequencer: arbitrates turn/hazard/brake requests
//                and drives both 3-lamp banks from a single-clock FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tail_light_ctrl
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] light_left,
    output logic [2:0] light_right,
    output logic       busy
);

    tl_state_t  state_q, state_d;
    logic       brake_q, brake_d;
    logic       run, clr, wrap;
    logic [1:0] phase;
    logic [2:0] brake_lamps;

    light_step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (clr),
        .phase (phase),
        .wrap  (wrap)
    );

    // Timer is cleared on every (re)entry so each sequence starts at phase 0.
    always_comb begin
        state_d = state_q;
        brake_d = brake;
        run     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                clr     = 1'b1;
                state_d = decide(left, right, hazard);
            end
            LEFT, RIGHT: begin
                run = 1'b1;
                if (hazard) begin
                    state_d = HAZARD;
                    clr     = 1'b1;
                end else if (wrap) begin
                    state_d = decide(left, right, hazard);
                    clr     = 1'b1;
                end
            end
            HAZARD: begin
                run = 1'b1;
                if (wrap) begin
                    state_d = decide(left, right, hazard);
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            brake_q <= brake_d;
        end
    end

    always_comb begin
        brake_lamps = brake_q ? LAMP_ALL : LAMP_OFF;
        light_left  = brake_lamps;
        light_right = brake_lamps;
        case (state_q)
            LEFT:    light_left  = pat(phase);
            RIGHT:   light_right = pat(phase);
            HAZARD: begin
                light_left  = pat(phase);
                light_right = pat(phase);
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule : tail_light_ctrl
`default_nettype wire
